// File: rtl/timer_bank_if.sv
`default_nettype none
// ============================================================================
// timer_bank_if : 8-bit SFR bus between the control unit and timer_bank
// Rev 1.0
// ============================================================================
interface timer_bank_if #(
  parameter int AW = 5
) ();
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic          rvalid;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, rvalid);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rvalid);
endinterface
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// timer_bank : CH-channel W-bit timer/counter bank (free-run, reload, one-shot, event)
// Rev 1.0
// ============================================================================
module timer_bank #(
  parameter int CH  = 2,
  parameter int W   = 16,
  parameter int PRE = 12
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  timer_bank_if.slave   bus,
  input  logic [CH-1:0] ev_in_i,
  input  logic [CH-1:0] gate_in_i,
  output logic [CH-1:0] irq_o,
  output logic [CH-1:0] ovf_pulse_o
);

  localparam int NB = W / 8;
  localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [CH-1:0] gate_s1_q, gate_s2_q;
  logic [CH-1:0] ev_s1_q, ev_s2_q, ev_s3_q;
  logic [CH-1:0] run_q, run_d, gate_en_q, gate_en_d, irq_en_q, irq_en_d;
  logic [CH-1:0] flag_q, flag_d, ovf_q, ovf_d;
  logic [1:0]    mode_q   [CH];
  logic [1:0]    mode_d   [CH];
  logic [W-1:0]  count_q  [CH];
  logic [W-1:0]  count_d  [CH];
  logic [W-1:0]  reload_q [CH];
  logic [W-1:0]  reload_d [CH];
  logic [W-1:0]  shadow_q [CH];
  logic [W-1:0]  shadow_d [CH];
  logic [7:0]    rdata_q, rdata_d;
  logic          rvalid_q;

  logic [31:0]   w_ch;
  logic [3:0]    w_reg;
  logic          w_sel;
  logic          w_tick;
  logic [CH-1:0] w_ev_rise, w_en, w_evt, w_wr, w_cnt_wr;

  assign w_ch      = 32'(bus.addr) >> 4;
  assign w_reg     = bus.addr[3:0];
  assign w_sel     = (w_ch < 32'(CH));
  assign w_tick    = (pre_q == PW'(PRE - 1));
  assign w_ev_rise = ev_s2_q & ~ev_s3_q;
  assign w_en      = run_q & (~gate_en_q | gate_s2_q);

  assign irq_o       = flag_q & irq_en_q;
  assign ovf_pulse_o = ovf_q;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;

  always_comb begin
    pre_d     = w_tick ? '0 : pre_q + 1'b1;
    run_d     = run_q;
    gate_en_d = gate_en_q;
    irq_en_d  = irq_en_q;
    flag_d    = flag_q;
    mode_d    = mode_q;
    count_d   = count_q;
    reload_d  = reload_q;
    shadow_d  = shadow_q;
    ovf_d     = '0;
    rdata_d   = '0;
    w_wr      = '0;
    w_evt     = '0;
    w_cnt_wr  = '0;
    for (int i = 0; i < CH; i++) begin
      w_wr[i]     = bus.wr_en && w_sel && (w_ch == 32'(i));
      w_evt[i]    = w_en[i] && ((mode_q[i] == 2'd3) ? w_ev_rise[i] : w_tick);
      w_cnt_wr[i] = w_wr[i] && (w_reg >= 4'd2) && (w_reg < 4'(2 + NB));

      // A CPU write to COUNT suppresses the concurrent increment and its overflow.
      if (w_cnt_wr[i]) begin
        for (int b = 0; b < NB; b++) begin
          if (w_reg == 4'(2 + b)) count_d[i][b*8 +: 8] = bus.wdata;
        end
      end else if (w_evt[i]) begin
        if (&count_q[i]) begin
          ovf_d[i]   = 1'b1;
          count_d[i] = (mode_q[i] == 2'd0) ? '0 : reload_q[i];
          if (mode_q[i] == 2'd2) run_d[i] = 1'b0;
        end else begin
          count_d[i] = count_q[i] + 1'b1;
        end
      end

      if (w_wr[i] && (w_reg == 4'd0)) begin
        run_d[i]     = bus.wdata[0];
        mode_d[i]    = bus.wdata[2:1];
        gate_en_d[i] = bus.wdata[3];
        irq_en_d[i]  = bus.wdata[4];
      end
      for (int b = 0; b < NB; b++) begin
        if (w_wr[i] && (w_reg == 4'(6 + b))) reload_d[i][b*8 +: 8] = bus.wdata;
      end
      flag_d[i] = (flag_q[i] & ~(w_wr[i] && (w_reg == 4'd1) && bus.wdata[0])) | ovf_d[i];

      if (bus.rd_en && w_sel && (w_ch == 32'(i))) begin
        if (w_reg == 4'd0) rdata_d = {3'b000, irq_en_q[i], gate_en_q[i], mode_q[i], run_q[i]};
        if (w_reg == 4'd1) rdata_d = {7'd0, flag_q[i]};
        for (int b = 0; b < NB; b++) begin
          if (w_reg == 4'(2 + b)) rdata_d = (b == 0) ? count_q[i][7:0] : shadow_q[i][b*8 +: 8];
          if (w_reg == 4'(6 + b)) rdata_d = reload_q[i][b*8 +: 8];
        end
        // Byte 0 read freezes the whole count so upper bytes read back coherently.
        if (w_reg == 4'd2) shadow_d[i] = count_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pre_q     <= '0;
      gate_s1_q <= '0;
      gate_s2_q <= '0;
      ev_s1_q   <= '0;
      ev_s2_q   <= '0;
      ev_s3_q   <= '0;
      run_q     <= '0;
      gate_en_q <= '0;
      irq_en_q  <= '0;
      flag_q    <= '0;
      ovf_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        mode_q[i]   <= '0;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      gate_s1_q <= gate_in_i;
      gate_s2_q <= gate_s1_q;
      ev_s1_q   <= ev_in_i;
      ev_s2_q   <= ev_s1_q;
      ev_s3_q   <= ev_s2_q;
      run_q     <= run_d;
      gate_en_q <= gate_en_d;
      irq_en_q  <= irq_en_d;
      flag_q    <= flag_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= bus.rd_en;
      for (int i = 0; i < CH; i++) begin
        mode_q[i]   <= mode_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// tb_timer_bank : directed and randomized checks of timer_bank against a tick-level model
module tb_timer_bank;
  localparam int CH  = 2;
  localparam int W   = 16;
  localparam int PRE = 12;
  localparam int AW  = $clog2(CH) + 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] ev, gate, irq, ovf;
  int            n_pass  = 0;
  int            n_total = 0;
  int            edge_n  = 0;
  int            pcnt [CH];

  timer_bank_if #(.AW(AW)) bus_if ();

  timer_bank #(.CH(CH), .W(W), .PRE(PRE)) dut (
    .clk_i      (clk),
    .reset_ni   (rst_n),
    .bus        (bus_if),
    .ev_in_i    (ev),
    .gate_in_i  (gate),
    .irq_o      (irq),
    .ovf_pulse_o(ovf)
  );

  always #5 clk = ~clk;

  // edge_n = number of rising edges since reset was released
  always @(posedge clk) edge_n <= rst_n ? edge_n + 1 : 0;

  initial for (int i = 0; i < CH; i++) pcnt[i] = 0;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < CH; i++) if (ovf[i] === 1'b1) pcnt[i] = pcnt[i] + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- bus helpers (enter and leave at a falling edge) ----------------
  task automatic wr(input int ch, input int r, input logic [7:0] d);
    bus_if.addr  = AW'((ch << 4) | r);
    bus_if.wdata = d;
    bus_if.wr_en = 1'b1;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
  endtask

  task automatic rd(input int ch, input int r, output logic [7:0] d);
    bus_if.addr  = AW'((ch << 4) | r);
    bus_if.rd_en = 1'b1;
    @(negedge clk);
    bus_if.rd_en = 1'b0;
    d = bus_if.rdata;
  endtask

  task automatic rd_count(input int ch, output logic [15:0] v);
    logic [7:0] lo, hi;
    rd(ch, 2, lo);
    rd(ch, 3, hi);
    v = {hi, lo};
  endtask

  task automatic wr_count(input int ch, input logic [15:0] v);
    wr(ch, 2, v[7:0]);
    wr(ch, 3, v[15:8]);
  endtask

  task automatic stop_clear(input int ch);
    wr(ch, 0, 8'h00);
    wr(ch, 1, 8'h01);
  endtask

  // next rising edge will be the one with (edge number mod PRE) == off
  task automatic align(input int off);
    for (int g = 0; g < 2 * PRE && ((edge_n + 1) % PRE) != off; g++) @(negedge clk);
  endtask

  // return just after the n-th prescaler tick edge from now
  task automatic skip_ticks(input int n);
    int seen = 0;
    for (int g = 0; g < (n + 1) * PRE && seen < n; g++) begin
      @(negedge clk);
      if (edge_n > 0 && (edge_n % PRE) == 0) seen++;
    end
  endtask

  task automatic pulse_ev(input int ch);
    ev[ch] = 1'b1;
    repeat (3) @(negedge clk);
    ev[ch] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    wr(0, 6, 8'hAB);
    wr_count(0, 16'hFFFF);
    wr(0, 0, 8'h13);
    wr(1, 7, 8'h5A);
    wr(1, 0, 8'h1F);
    repeat (20) @(negedge clk);
    rd(0, 6, d);
    do_reset();
    n_total++; if (irq !== '0) $display("FAIL reset_irq got=%b exp=00", irq); else n_pass++;
    n_total++; if (ovf !== '0) $display("FAIL reset_ovf got=%b exp=00", ovf); else n_pass++;
    n_total++; if (bus_if.rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", bus_if.rdata); else n_pass++;
    n_total++; if (bus_if.rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", bus_if.rvalid); else n_pass++;
    for (int c = 0; c < CH; c++) begin
      wr(c, 4, 8'hFF); wr(c, 5, 8'hFF); wr(c, 8, 8'hFF); wr(c, 9, 8'hFF);
      for (int r = 10; r < 16; r++) wr(c, r, 8'hFF);
    end
    for (int c = 0; c < CH; c++) begin
      for (int r = 0; r < 16; r++) begin
        rd(c, r, d);
        n_total++; if (d !== 8'h00) $display("FAIL reset_reg ch=%0d reg=%0d got=%h exp=00", c, r, d); else n_pass++;
      end
    end
    rd(0, 0, d);
    n_total++; if (bus_if.rvalid !== 1'b1) $display("FAIL rvalid_pulse got=%b exp=1", bus_if.rvalid); else n_pass++;
    @(negedge clk);
    n_total++; if (bus_if.rvalid !== 1'b0) $display("FAIL rvalid_drop got=%b exp=0", bus_if.rvalid); else n_pass++;
  endtask

  task automatic test_first_tick();
    logic [7:0] d;
    do_reset();
    wr(0, 0, 8'h01);
    align(0);
    rd(0, 2, d);
    n_total++; if (d !== 8'h00) $display("FAIL first_tick_before got=%h exp=00", d); else n_pass++;
    rd(0, 2, d);
    n_total++; if (d !== 8'h01) $display("FAIL first_tick_after got=%h exp=01", d); else n_pass++;
    wr(0, 0, 8'h00);
  endtask

  task automatic test_mode0();
    logic [15:0] v;
    logic [7:0]  d;
    int          base;
    stop_clear(0);
    align(1);
    wr_count(0, 16'hFFFE);
    base = pcnt[0];
    wr(0, 0, 8'h01);
    skip_ticks(2);
    rd_count(0, v);
    n_total++; if (v !== 16'h0000) $display("FAIL mode0_count got=%h exp=0000", v); else n_pass++;
    rd(0, 1, d);
    n_total++; if (d !== 8'h01) $display("FAIL mode0_flag got=%h exp=01", d); else n_pass++;
    n_total++; if (pcnt[0] - base !== 1) $display("FAIL mode0_pulses got=%0d exp=1", pcnt[0] - base); else n_pass++;
    n_total++; if (irq[0] !== 1'b0) $display("FAIL mode0_irq_masked got=%b exp=0", irq[0]); else n_pass++;
    wr(0, 0, 8'h11);
    n_total++; if (irq[0] !== 1'b1) $display("FAIL mode0_irq_en got=%b exp=1", irq[0]); else n_pass++;
    wr(0, 1, 8'h01);
    n_total++; if (irq[0] !== 1'b0) $display("FAIL mode0_irq_clr got=%b exp=0", irq[0]); else n_pass++;
    wr(0, 0, 8'h00);
  endtask

  task automatic test_oneshot();
    logic [15:0] v;
    logic [7:0]  d;
    stop_clear(1);
    wr(1, 6, 8'h34);
    wr(1, 7, 8'h12);
    align(1);
    wr_count(1, 16'hFFFF);
    wr(1, 0, 8'h05);
    skip_ticks(1);
    rd_count(1, v);
    n_total++; if (v !== 16'h1234) $display("FAIL oneshot_reload got=%h exp=1234", v); else n_pass++;
    rd(1, 0, d);
    n_total++; if (d !== 8'h04) $display("FAIL oneshot_ctrl got=%h exp=04", d); else n_pass++;
    skip_ticks(100);
    rd_count(1, v);
    n_total++; if (v !== 16'h1234) $display("FAIL oneshot_hold got=%h exp=1234", v); else n_pass++;
    rd(1, 1, d);
    n_total++; if (d !== 8'h01) $display("FAIL oneshot_flag got=%h exp=01", d); else n_pass++;
  endtask

  task automatic test_event();
    logic [15:0] v, rl, exp_c;
    int          n;
    stop_clear(0);
    wr_count(0, 16'h0000);
    gate = '0;
    wr(0, 0, 8'h0F);
    for (int p = 0; p < 5; p++) pulse_ev(0);
    repeat (4) @(negedge clk);
    rd_count(0, v);
    n_total++; if (v !== 16'h0000) $display("FAIL event_gated got=%h exp=0000", v); else n_pass++;
    gate[0] = 1'b1;
    repeat (3) @(negedge clk);
    n = $urandom_range(1, 9);
    for (int p = 0; p < n; p++) pulse_ev(0);
    repeat (4) @(negedge clk);
    rd_count(0, v);
    n_total++; if (v !== 16'(n)) $display("FAIL event_count got=%h exp=%h", v, 16'(n)); else n_pass++;
    // overflow in event mode reloads
    stop_clear(0);
    rl = 16'($urandom);
    wr(0, 6, rl[7:0]);
    wr(0, 7, rl[15:8]);
    wr_count(0, 16'hFFFE);
    wr(0, 0, 8'h07);
    exp_c = 16'hFFFE;
    for (int p = 0; p < 3; p++) begin
      pulse_ev(0);
      exp_c = (exp_c == 16'hFFFF) ? rl : exp_c + 16'd1;
    end
    repeat (4) @(negedge clk);
    rd_count(0, v);
    n_total++; if (v !== exp_c) $display("FAIL event_reload got=%h exp=%h", v, exp_c); else n_pass++;
    wr(0, 0, 8'h00);
    gate = '0;
  endtask

  task automatic test_snapshot();
    logic [7:0]  d;
    logic [15:0] v;
    stop_clear(0);
    align(1);
    wr_count(0, 16'h00FE);
    wr(0, 0, 8'h01);
    skip_ticks(1);
    rd(0, 2, d);
    n_total++; if (d !== 8'hFF) $display("FAIL snap_lo got=%h exp=ff", d); else n_pass++;
    skip_ticks(2);
    rd(0, 3, d);
    n_total++; if (d !== 8'h00) $display("FAIL snap_hi got=%h exp=00", d); else n_pass++;
    rd_count(0, v);
    n_total++; if (v !== 16'h0101) $display("FAIL snap_fresh got=%h exp=0101", v); else n_pass++;
    wr(0, 0, 8'h00);
  endtask

  task automatic test_collisions();
    logic [15:0] v;
    logic [7:0]  d;
    int          base;
    // byte write on a tick edge
    stop_clear(0);
    align(1);
    wr_count(0, 16'h12FF);
    wr(0, 0, 8'h01);
    align(0);
    wr(0, 2, 8'h55);
    rd_count(0, v);
    n_total++; if (v !== 16'h1255) $display("FAIL coll_bytewr got=%h exp=1255", v); else n_pass++;
    // write to COUNT at an overflow edge suppresses the overflow
    stop_clear(0);
    align(1);
    wr_count(0, 16'hFFFF);
    base = pcnt[0];
    wr(0, 0, 8'h01);
    align(0);
    wr(0, 3, 8'hFF);
    rd_count(0, v);
    n_total++; if (v !== 16'hFFFF) $display("FAIL coll_noovf_count got=%h exp=ffff", v); else n_pass++;
    rd(0, 1, d);
    n_total++; if (d !== 8'h00) $display("FAIL coll_noovf_flag got=%h exp=00", d); else n_pass++;
    n_total++; if (pcnt[0] - base !== 0) $display("FAIL coll_noovf_pulse got=%0d exp=0", pcnt[0] - base); else n_pass++;
    wr(0, 0, 8'h00);
    // overflow coincident with STATUS W1C
    stop_clear(0);
    align(1);
    wr_count(0, 16'hFFFF);
    wr(0, 0, 8'h01);
    align(0);
    wr(0, 1, 8'h01);
    rd(0, 1, d);
    n_total++; if (d !== 8'h01) $display("FAIL coll_w1c_flag got=%h exp=01", d); else n_pass++;
    // CTRL run=0 coincident with overflow
    wr(0, 1, 8'h01);
    wr_count(0, 16'hFFFF);
    align(0);
    wr(0, 0, 8'h00);
    rd(0, 1, d);
    n_total++; if (d !== 8'h01) $display("FAIL coll_stop_flag got=%h exp=01", d); else n_pass++;
    skip_ticks(1);
    rd_count(0, v);
    n_total++; if (v !== 16'h0000) $display("FAIL coll_stop_count got=%h exp=0000", v); else n_pass++;
    rd(0, 0, d);
    n_total++; if (d !== 8'h00) $display("FAIL coll_stop_ctrl got=%h exp=00", d); else n_pass++;
    // read and write of the same register together return the old value
    wr(1, 6, 8'h3C);
    bus_if.addr  = AW'((1 << 4) | 6);
    bus_if.wdata = 8'hA5;
    bus_if.wr_en = 1'b1;
    bus_if.rd_en = 1'b1;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    n_total++; if (bus_if.rdata !== 8'h3C) $display("FAIL rdwr_old got=%h exp=3c", bus_if.rdata); else n_pass++;
    rd(1, 6, d);
    n_total++; if (d !== 8'hA5) $display("FAIL rdwr_new got=%h exp=a5", d); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] v, rl, start, c;
    logic [7:0]  d, exp_ctrl;
    logic [1:0]  md;
    logic        ie, mrun;
    int          ch, k, novf, base;
    for (int it = 0; it < 10; it++) begin
      ch    = $urandom_range(0, CH - 1);
      md    = 2'($urandom_range(0, 2));
      ie    = 1'($urandom_range(0, 1));
      rl    = 16'($urandom);
      start = 16'hFFFF - 16'($urandom_range(0, 4));
      k     = $urandom_range(1, 6);
      // reference: apply k timer ticks to the channel
      c = start; mrun = 1'b1; novf = 0;
      for (int t = 0; t < k; t++) begin
        if (mrun) begin
          if (c == 16'hFFFF) begin
            novf++;
            c = (md == 2'd0) ? 16'h0000 : rl;
            if (md == 2'd2) mrun = 1'b0;
          end else begin
            c = c + 16'd1;
          end
        end
      end
      exp_ctrl = {3'b000, ie, 1'b0, md, mrun};
      stop_clear(ch);
      align(1);
      wr(ch, 6, rl[7:0]);
      wr(ch, 7, rl[15:8]);
      wr_count(ch, start);
      base = pcnt[ch];
      wr(ch, 0, {3'b000, ie, 1'b0, md, 1'b1});
      skip_ticks(k);
      rd_count(ch, v);
      n_total++; if (v !== c) $display("FAIL rand_count it=%0d ch=%0d got=%h exp=%h", it, ch, v, c); else n_pass++;
      rd(ch, 0, d);
      n_total++; if (d !== exp_ctrl) $display("FAIL rand_ctrl it=%0d got=%h exp=%h", it, d, exp_ctrl); else n_pass++;
      rd(ch, 1, d);
      n_total++; if (d !== {7'd0, novf > 0}) $display("FAIL rand_flag it=%0d got=%h exp=%0d", it, d, novf > 0); else n_pass++;
      n_total++; if (irq[ch] !== ((novf > 0) && ie)) $display("FAIL rand_irq it=%0d got=%b exp=%b", it, irq[ch], (novf > 0) && ie); else n_pass++;
      wr(ch, 0, 8'h00);
      n_total++; if (pcnt[ch] - base !== novf) $display("FAIL rand_pulses it=%0d got=%0d exp=%0d", it, pcnt[ch] - base, novf); else n_pass++;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    ev           = '0;
    gate         = '0;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    @(negedge clk);
    test_reset();
    test_first_tick();
    test_mode0();
    test_oneshot();
    test_event();
    test_snapshot();
    test_collisions();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
